store_station_multi: RTL and testbench

//  Parametrised in-order store reservation station for the Tomasulo core, successor to the single-slot store station.

---
 rtl/store_station_multi.sv | 214 +++++++++++++++++++++
 tb/tb_store_station_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/store_station_multi.sv
// In-order store reservation station: a circular buffer of pending stores that
// snoops several broadcast channels and issues only the oldest entry once its operands are ready.
module store_station_multi #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int LABEL_W  = 5,
  parameter int OP_W     = 5,
  parameter int NUM_BC   = 2,
  parameter int TAG_BASE = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        EXEable,
  input  logic                        WEN,
  input  logic [OP_W-1:0]             opCode,
  input  logic [OP_W-1:0]             func,
  input  logic [DATA_W-1:0]           dataIn1,
  input  logic [LABEL_W-1:0]          label1,
  input  logic [DATA_W-1:0]           dataIn2,
  input  logic [LABEL_W-1:0]          label2,
  input  logic [DATA_W-1:0]           Imm,
  input  logic                        flush,
  input  logic [NUM_BC-1:0]           BCEN,
  input  logic [NUM_BC*LABEL_W-1:0]   BClabel,
  input  logic [NUM_BC*DATA_W-1:0]    BCdata,
  output logic [OP_W-1:0]             opOut,
  output logic [OP_W-1:0]             funcOut,
  output logic [DATA_W-1:0]           dataOut1,
  output logic [DATA_W-1:0]           dataOut2,
  output logic [LABEL_W-1:0]          labelOut,
  output logic                        OutEn,
  output logic                        isFull,
  output logic [LABEL_W-1:0]          allocLabel
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [OP_W-1:0]    op_q   [DEPTH-1:0];
  logic [OP_W-1:0]    op_d   [DEPTH-1:0];
  logic [OP_W-1:0]    func_q [DEPTH-1:0];
  logic [OP_W-1:0]    func_d [DEPTH-1:0];
  logic [DATA_W-1:0]  v1_q   [DEPTH-1:0];
  logic [DATA_W-1:0]  v1_d   [DEPTH-1:0];
  logic [DATA_W-1:0]  v2_q   [DEPTH-1:0];
  logic [DATA_W-1:0]  v2_d   [DEPTH-1:0];
  logic [DATA_W-1:0]  imm_q  [DEPTH-1:0];
  logic [DATA_W-1:0]  imm_d  [DEPTH-1:0];
  logic [LABEL_W-1:0] q1_q   [DEPTH-1:0];
  logic [LABEL_W-1:0] q1_d   [DEPTH-1:0];
  logic [LABEL_W-1:0] q2_q   [DEPTH-1:0];
  logic [LABEL_W-1:0] q2_d   [DEPTH-1:0];

  logic               out_en_q, out_en_d;
  logic [OP_W-1:0]    op_out_q, op_out_d, func_out_q, func_out_d;
  logic [DATA_W-1:0]  addr_q, addr_d, sdata_q, sdata_d;
  logic [LABEL_W-1:0] label_out_q, label_out_d;

  logic is_full, wr_ok, issue;

  // Label 0 means "no producer" and must never match a broadcast.
  function automatic logic bc_hit(input logic [LABEL_W-1:0] lbl);
    bc_hit = 1'b0;
    for (int c = 0; c < NUM_BC; c++) begin
      if (BCEN[c] && (lbl != '0) && (BClabel[c*LABEL_W +: LABEL_W] == lbl)) bc_hit = 1'b1;
    end
  endfunction

  // Scan from the top channel down so the lowest matching channel wins.
  function automatic logic [DATA_W-1:0] bc_val(input logic [LABEL_W-1:0] lbl);
    bc_val = '0;
    for (int c = NUM_BC - 1; c >= 0; c--) begin
      if (BCEN[c] && (BClabel[c*LABEL_W +: LABEL_W] == lbl)) bc_val = BCdata[c*DATA_W +: DATA_W];
    end
  endfunction

  assign is_full = (count_q == CNT_W'(DEPTH));
  assign wr_ok   = WEN && !is_full;
  assign issue   = busy_q[head_q] && (q1_q[head_q] == '0) && (q2_q[head_q] == '0) && EXEable;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    busy_d      = busy_q;
    op_d        = op_q;
    func_d      = func_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    imm_d       = imm_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    out_en_d    = 1'b0;
    op_out_d    = op_out_q;
    func_out_d  = func_out_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    label_out_d = label_out_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && (q1_q[i] != '0) && bc_hit(q1_q[i])) begin
        v1_d[i] = bc_val(q1_q[i]);
        q1_d[i] = '0;
      end
      if (busy_q[i] && (q2_q[i] != '0) && bc_hit(q2_q[i])) begin
        v2_d[i] = bc_val(q2_q[i]);
        q2_d[i] = '0;
      end
    end

    if (issue) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
      out_en_d       = 1'b1;
      op_out_d       = op_q[head_q];
      func_out_d     = func_q[head_q];
      addr_d         = v1_q[head_q] + imm_q[head_q];
      sdata_d        = v2_q[head_q];
      label_out_d    = LABEL_W'(TAG_BASE) + LABEL_W'(head_q);
    end

    // The tail slot is never the issuing head: issue needs count>0 and write needs count<DEPTH.
    if (wr_ok) begin
      busy_d[tail_q] = 1'b1;
      op_d[tail_q]   = opCode;
      func_d[tail_q] = func;
      imm_d[tail_q]  = Imm;
      if (bc_hit(label1)) begin
        v1_d[tail_q] = bc_val(label1);
        q1_d[tail_q] = '0;
      end else begin
        v1_d[tail_q] = dataIn1;
        q1_d[tail_q] = label1;
      end
      if (bc_hit(label2)) begin
        v2_d[tail_q] = bc_val(label2);
        q2_d[tail_q] = '0;
      end else begin
        v2_d[tail_q] = dataIn2;
        q2_d[tail_q] = label2;
      end
      tail_d = tail_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(wr_ok) - CNT_W'(issue);

    if (flush) begin
      busy_d      = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      out_en_d    = 1'b0;
      op_out_d    = '0;
      func_out_d  = '0;
      addr_d      = '0;
      sdata_d     = '0;
      label_out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      out_en_q    <= 1'b0;
      op_out_q    <= '0;
      func_out_q  <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      label_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        func_q[i] <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        imm_q[i]  <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      out_en_q    <= out_en_d;
      op_out_q    <= op_out_d;
      func_out_q  <= func_out_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      label_out_q <= label_out_d;
      op_q        <= op_d;
      func_q      <= func_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      imm_q       <= imm_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
    end
  end

  assign opOut      = op_out_q;
  assign funcOut    = func_out_q;
  assign dataOut1   = addr_q;
  assign dataOut2   = sdata_q;
  assign labelOut   = label_out_q;
  assign OutEn      = out_en_q;
  assign isFull     = is_full;
  assign allocLabel = LABEL_W'(TAG_BASE) + LABEL_W'(tail_q);

endmodule

// File: tb/tb_store_station_multi.sv
// Directed bench for store_station_multi: hand-computed vectors checked with immediate assertions.
module tb_store_station_multi;

  logic        clk = 1'b0;
  logic        rstn, EXEable, WEN, flush;
  logic [4:0]  opCode, func, label1, label2;
  logic [31:0] dataIn1, dataIn2, Imm;
  logic [1:0]  BCEN;
  logic [9:0]  BClabel;
  logic [63:0] BCdata;
  logic [4:0]  opOut, funcOut, labelOut, allocLabel;
  logic [31:0] dataOut1, dataOut2;
  logic        OutEn, isFull;

  int n_cmp = 0;
  int n_err = 0;

  store_station_multi dut (
    .clk(clk), .rstn(rstn), .EXEable(EXEable), .WEN(WEN),
    .opCode(opCode), .func(func), .dataIn1(dataIn1), .label1(label1),
    .dataIn2(dataIn2), .label2(label2), .Imm(Imm), .flush(flush),
    .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .opOut(opOut), .funcOut(funcOut), .dataOut1(dataOut1), .dataOut2(dataOut2),
    .labelOut(labelOut), .OutEn(OutEn), .isFull(isFull), .allocLabel(allocLabel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] op, input logic [31:0] d1, input logic [4:0] l1,
                    input logic [31:0] d2, input logic [4:0] l2, input logic [31:0] imm);
    WEN = 1'b1; opCode = op; func = op + 5'd1;
    dataIn1 = d1; label1 = l1; dataIn2 = d2; label2 = l2; Imm = imm;
  endtask

  initial begin
    rstn = 1'b0; EXEable = 1'b0; WEN = 1'b0; flush = 1'b0;
    opCode = '0; func = '0; label1 = '0; label2 = '0;
    dataIn1 = '0; dataIn2 = '0; Imm = '0;
    BCEN = '0; BClabel = '0; BCdata = '0;

    // Reset
    step(); step();
    chk("rst_outen", OutEn, 0);
    chk("rst_full", isFull, 0);
    chk("rst_alloc", allocLabel, 8);
    chk("rst_op", opOut, 0);
    chk("rst_func", funcOut, 0);
    chk("rst_d1", dataOut1, 0);
    chk("rst_d2", dataOut2, 0);
    chk("rst_label", labelOut, 0);
    rstn = 1'b1;

    // Ready store: issues one edge after the write
    EXEable = 1'b1;
    wr(5'd1, 32'd4, 5'd0, 32'd2, 5'd0, 32'd1);
    step();
    WEN = 1'b0;
    chk("rdy_no_early", OutEn, 0);
    chk("rdy_alloc", allocLabel, 9);
    step();
    $display("ready store: OutEn=%0d addr=%0h data=%0h tag=%0d", OutEn, dataOut1, dataOut2, labelOut);
    chk("rdy_outen", OutEn, 1);
    chk("rdy_addr", dataOut1, 5);
    chk("rdy_data", dataOut2, 2);
    chk("rdy_tag", labelOut, 8);
    chk("rdy_op", opOut, 1);
    chk("rdy_func", funcOut, 2);
    step();
    chk("rdy_pulse", OutEn, 0);
    chk("rdy_hold", dataOut1, 5);

    // Pending store resolved by channel 0
    wr(5'd2, 32'd8, 5'd0, 32'd0, 5'd2, 32'd0);
    step();
    WEN = 1'b0;
    BCEN = 2'b01; BClabel = {5'd0, 5'd2}; BCdata = {32'd0, 32'd32};
    step();
    BCEN = 2'b00;
    chk("pend_wait", OutEn, 0);
    step();
    $display("pending store: OutEn=%0d addr=%0h data=%0h tag=%0d", OutEn, dataOut1, dataOut2, labelOut);
    chk("pend_outen", OutEn, 1);
    chk("pend_data", dataOut2, 32);
    chk("pend_addr", dataOut1, 8);
    chk("pend_tag", labelOut, 9);

    // Flush to realign pointers, then order/full test
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl0_alloc", allocLabel, 8);
    wr(5'd4, 32'd100, 5'd0, 32'd0, 5'd3, 32'd0);
    step();
    chk("ord_w1", OutEn, 0);
    wr(5'd4, 32'd200, 5'd0, 32'd20, 5'd0, 32'd1);
    step();
    chk("ord_w2", OutEn, 0);
    wr(5'd4, 32'd300, 5'd0, 32'd30, 5'd0, 32'd1);
    step();
    chk("ord_w3", OutEn, 0);
    wr(5'd4, 32'd400, 5'd0, 32'd40, 5'd0, 32'd1);
    step();
    chk("ord_w4", OutEn, 0);
    chk("ord_full", isFull, 1);
    chk("ord_alloc_wrap", allocLabel, 8);
    wr(5'd4, 32'd999, 5'd0, 32'd999, 5'd0, 32'd0);
    step();
    WEN = 1'b0;
    chk("ord_drop_full", isFull, 1);
    chk("ord_drop_alloc", allocLabel, 8);
    chk("ord_stall", OutEn, 0);
    BCEN = 2'b10; BClabel = {5'd3, 5'd0}; BCdata = {32'd77, 32'd0};
    step();
    BCEN = 2'b00;
    chk("ord_resolve", OutEn, 0);
    step();
    chk("ord0_en", OutEn, 1); chk("ord0_tag", labelOut, 8);
    chk("ord0_addr", dataOut1, 100); chk("ord0_data", dataOut2, 77);
    step();
    chk("ord1_en", OutEn, 1); chk("ord1_tag", labelOut, 9);
    chk("ord1_addr", dataOut1, 201); chk("ord1_data", dataOut2, 20);
    step();
    chk("ord2_en", OutEn, 1); chk("ord2_tag", labelOut, 10);
    chk("ord2_addr", dataOut1, 301); chk("ord2_data", dataOut2, 30);
    step();
    chk("ord3_en", OutEn, 1); chk("ord3_tag", labelOut, 11);
    chk("ord3_addr", dataOut1, 401); chk("ord3_data", dataOut2, 40);
    step();
    $display("order test: drained, OutEn=%0d isFull=%0d", OutEn, isFull);
    chk("ord_empty", OutEn, 0);
    chk("ord_notfull", isFull, 0);

    // Write-cycle bypass after the tail wrapped
    wr(5'd6, 32'd0, 5'd5, 32'd9, 5'd0, 32'd4);
    BCEN = 2'b01; BClabel = {5'd0, 5'd5}; BCdata = {32'd0, 32'h100};
    step();
    WEN = 1'b0; BCEN = 2'b00;
    step();
    $display("bypass: OutEn=%0d addr=%0h tag=%0d", OutEn, dataOut1, labelOut);
    chk("byp_outen", OutEn, 1);
    chk("byp_addr", dataOut1, 32'h104);
    chk("byp_data", dataOut2, 9);
    chk("byp_tag", labelOut, 8);

    // Two channels with the same label: channel 0 wins
    wr(5'd7, 32'd0, 5'd0, 32'd0, 5'd6, 32'd0);
    step();
    WEN = 1'b0;
    BCEN = 2'b11; BClabel = {5'd6, 5'd6}; BCdata = {32'd22, 32'd11};
    step();
    BCEN = 2'b00;
    step();
    chk("prio_outen", OutEn, 1);
    chk("prio_data", dataOut2, 11);
    chk("prio_tag", labelOut, 9);

    // Flush with three busy entries; the concurrent write is ignored
    EXEable = 1'b0;
    wr(5'd1, 32'd1, 5'd0, 32'd1, 5'd0, 32'd0); step();
    wr(5'd1, 32'd2, 5'd0, 32'd2, 5'd0, 32'd0); step();
    wr(5'd1, 32'd3, 5'd0, 32'd3, 5'd0, 32'd0); step();
    chk("fl_stall", OutEn, 0);
    chk("fl_pre_alloc", allocLabel, 9);
    flush = 1'b1;
    wr(5'd1, 32'd4, 5'd0, 32'd4, 5'd0, 32'd0);
    EXEable = 1'b1;
    step();
    flush = 1'b0; WEN = 1'b0;
    chk("fl_outen", OutEn, 0);
    chk("fl_full", isFull, 0);
    chk("fl_alloc", allocLabel, 8);
    step();
    $display("flush: OutEn=%0d allocLabel=%0d", OutEn, allocLabel);
    chk("fl_empty", OutEn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
